// File: rtl/uart_tx_if.sv
// Bus-side byte handshake between the register block and the UART transmitter.
// Register block is master (we/txdata); transmitter is slave (ready/busy/done/state).
interface uart_tx_if;
    logic       we;
    logic [7:0] txdata;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] tx_state;

    modport master (
        output we,
        output txdata,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_state
    );

    modport slave (
        input  we,
        input  txdata,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_state
    );
endinterface

// File: rtl/uart_tx.sv
// UART 8N1 serialiser (8E1/8O1 when UART_TX_PARITY_EN is defined), bits timed by OSR s_tick pulses.
// Latency: tx drops to the start bit 1 clk after an accepted we; tx_done pulses 1 clk at end of stop bit.
// Backpressure: we is accepted only while tx_ready=1 (IDLE); writes while busy are silently dropped.
module uart_tx #(
    parameter int OSR        = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     s_tick,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam int             TW        = $clog2(OSR);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b111,
        STOP   = 3'b010
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt, tick_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    txbuf, txbuf_n;
    logic          tx_n;
    logic          tx_done_q, tx_done_n;
    logic          bit_end;

`ifndef UART_TX_PARITY_EN
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    assign bit_end = s_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            txbuf     <= '0;
            tx        <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            txbuf     <= txbuf_n;
            tx        <= tx_n;
            tx_done_q <= tx_done_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        txbuf_n    = txbuf;
        tx_n       = tx;
        tx_done_n  = 1'b0;

        // Bit timer runs only while a frame is in flight and only on s_tick.
        if (state != IDLE && s_tick) begin
            tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (bus.we) begin
                    txbuf_n    = bus.txdata;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = txbuf[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = (^txbuf) ^ PARITY_ODD;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        tx_n = txbuf[bit_cnt + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n   = IDLE;
                    tx_n      = 1'b1;
                    tx_done_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_state = state;

endmodule
